// File: rtl/pigro_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pigro_pkg
//  Description : Shared constants, execute-bound payload type and immediate
//                sign-extension helper for the pigro operand-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pigro_pkg;

    localparam int DATA_W = 32;
    localparam int AW     = 4;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 16;
    localparam int SB_MAX = 3;
    localparam int NREG   = 1 << AW;
    localparam int CNT_W  = 2;

    localparam logic [CNT_W-1:0] SB_MAX_CNT = CNT_W'(SB_MAX);

    // Payload registered toward execute
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [AW-1:0]     rd;
        logic              wr;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } ex_pkt_t;

    function automatic logic [DATA_W-1:0] sign_extend(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_if
//  Description : Decode-side and execute-side valid/ready channels of the
//                operand-fetch stage. The slave view is the stage itself, the
//                master view is its surroundings (decode plus execute).
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_fetch_if;
    import pigro_pkg::*;

    // Decode -> operand fetch
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [AW-1:0]     in_rd;
    logic              in_wr;
    logic [AW-1:0]     in_ra;
    logic [AW-1:0]     in_rb;
    logic              in_use_imm;
    logic [IMM_W-1:0]  in_imm;

    // Operand fetch -> execute
    logic              ex_valid;
    logic              ex_ready;
    logic [OP_W-1:0]   ex_op;
    logic [AW-1:0]     ex_rd;
    logic              ex_wr;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;

    modport slave (
        input  in_valid, in_op, in_rd, in_wr, in_ra, in_rb, in_use_imm, in_imm,
        output in_ready,
        output ex_valid, ex_op, ex_rd, ex_wr, ex_a, ex_b,
        input  ex_ready
    );

    modport master (
        output in_valid, in_op, in_rd, in_wr, in_ra, in_rb, in_use_imm, in_imm,
        input  in_ready,
        input  ex_valid, ex_op, ex_rd, ex_wr, ex_a, ex_b,
        output ex_ready
    );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Per-register count of in-flight writes. Issue increments,
//                writeback decrements; both on one register cancel out. Exposes
//                clear/bypassable queries for two source ports and a full query
//                for the destination port.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import pigro_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          inc,
    input  wire logic [AW-1:0] inc_ad,
    input  wire logic          dec,
    input  wire logic [AW-1:0] dec_ad,
    input  wire logic [AW-1:0] qa_ad,
    input  wire logic [AW-1:0] qb_ad,
    input  wire logic [AW-1:0] qd_ad,
    output logic               qa_clear,
    output logic               qa_bypass,
    output logic               qb_clear,
    output logic               qb_bypass,
    output logic               qd_full,
    output logic [NREG-1:0]    busy
);

    logic [CNT_W-1:0] cnt_view [NREG];

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            logic             hit_inc;
            logic             hit_dec;
            logic [CNT_W-1:0] cnt;

            assign hit_inc = inc && (inc_ad == AW'(r));
            assign hit_dec = dec && (dec_ad == AW'(r));

            // Counter update; a decrement at zero is dropped, increment saturates
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (hit_inc && !hit_dec) begin
                    if (cnt != SB_MAX_CNT) begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (hit_dec && !hit_inc) begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end

            assign cnt_view[r] = cnt;
            assign busy[r]     = (cnt != '0);
        end
    endgenerate

    // Port queries against the counts as they stand before this cycle's update
    always_comb begin
        qa_clear  = (cnt_view[qa_ad] == '0);
        qa_bypass = (cnt_view[qa_ad] == CNT_W'(1));
        qb_clear  = (cnt_view[qb_ad] == '0);
        qb_bypass = (cnt_view[qb_ad] == CNT_W'(1));
        qd_full   = (cnt_view[qd_ad] == SB_MAX_CNT);
    end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Operand-fetch stage between decode and execute. Reads the
//                register file, bypasses same-cycle writeback data, stalls on
//                scoreboard hazards and registers resolved operands toward
//                execute over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import pigro_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    operand_fetch_if.slave         bus,
    output logic [AW-1:0]          rf_ad_a,
    output logic [AW-1:0]          rf_ad_b,
    input  wire logic [DATA_W-1:0] rf_o_a,
    input  wire logic [DATA_W-1:0] rf_o_b,
    input  wire logic              wb_we,
    input  wire logic [AW-1:0]     wb_ad,
    input  wire logic [DATA_W-1:0] wb_d,
    output logic [NREG-1:0]        sb_busy
);

    logic              qa_clear, qa_bypass;
    logic              qb_clear, qb_bypass;
    logic              qd_full;
    logic              wb_hits_a, wb_hits_b, wb_hits_d;
    logic              a_ok, b_ok, full_block, hazard;
    logic              ready, accept;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    ex_pkt_t           ex_next;
    ex_pkt_t           ex_q;
    logic              ex_valid_q;

    assign rf_ad_a = bus.in_ra;
    assign rf_ad_b = bus.in_rb;

    reg_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc       (accept && bus.in_wr),
        .inc_ad    (bus.in_rd),
        .dec       (wb_we),
        .dec_ad    (wb_ad),
        .qa_ad     (bus.in_ra),
        .qb_ad     (bus.in_rb),
        .qd_ad     (bus.in_rd),
        .qa_clear  (qa_clear),
        .qa_bypass (qa_bypass),
        .qb_clear  (qb_clear),
        .qb_bypass (qb_bypass),
        .qd_full   (qd_full),
        .busy      (sb_busy)
    );

    // Source resolution: register file when clear, writeback data when the
    // only outstanding write retires this cycle, otherwise a hazard
    always_comb begin
        wb_hits_a = wb_we && (wb_ad == bus.in_ra);
        wb_hits_b = wb_we && (wb_ad == bus.in_rb);
        wb_hits_d = wb_we && (wb_ad == bus.in_rd);

        a_ok   = qa_clear || (qa_bypass && wb_hits_a);
        opnd_a = qa_clear ? rf_o_a : wb_d;

        if (bus.in_use_imm) begin
            b_ok   = 1'b1;
            opnd_b = sign_extend(bus.in_imm);
        end else begin
            b_ok   = qb_clear || (qb_bypass && wb_hits_b);
            opnd_b = qb_clear ? rf_o_b : wb_d;
        end

        // A saturated destination count only blocks if nothing retires it now
        full_block = bus.in_wr && qd_full && !wb_hits_d;
        hazard     = !a_ok || !b_ok || full_block;
    end

    assign ready        = !hazard && (!ex_valid_q || bus.ex_ready);
    assign accept       = bus.in_valid && ready;
    assign bus.in_ready = ready;

    always_comb begin
        ex_next.op = bus.in_op;
        ex_next.rd = bus.in_rd;
        ex_next.wr = bus.in_wr;
        ex_next.a  = opnd_a;
        ex_next.b  = opnd_b;
    end

    // Output register: load on accept, drain on ex_ready, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= ex_next;
        end else if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_op    = ex_q.op;
    assign bus.ex_rd    = ex_q.rd;
    assign bus.ex_wr    = ex_q.wr;
    assign bus.ex_a     = ex_q.a;
    assign bus.ex_b     = ex_q.b;

endmodule
`default_nettype wire
